pong_game_ctrl: RTL and testbench
=================================

# pong_game_ctrl

Game-flow controller for the Pong datapath. It sequences the pixel/animation generator through idle, serve, play, miss and game-over phases, paced by the 60 Hz frame tick. It gates ball motion, requests ball re-centring, and keeps score, lives and speed level for the animation and score display. It sits beside the pixel generator and the frame-tick generator in the top module, downstream of the reset synchroniser.

## Interface
- LIVES, 3: lives per game, 1..3.
- SERVE_FRAMES, 60: frame ticks the ball rests before a serve.
- MISS_FRAMES, 120: frame ticks of pause after a miss.
- HITS_PER_LEVEL, 4: paddle hits per speed-level increment.
- MAX_LEVEL, 3: saturation value of level, ≤3.

- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- tick60  in  1  single-cycle pulse once per frame.
- btn_start  in  1  debounced start button, level.
- hit  in  1  single-cycle pulse: ball hit paddle.
- miss  in  1  single-cycle pulse: ball passed paddle.
- ball_run  out  1  ball motion enable to animation.
- ball_load  out  1  one-cycle pulse: re-centre ball.
- score_bcd  out  8  two BCD digits, [7:4] tens.
- lives  out  2  remaining lives.
- level  out  2  speed level for ball step size.
- state  out  3  IDLE=0, SERVE=1, PLAY=2, MISS=3, OVER=4.
- game_over  out  1  high while in OVER.

## Operation
- All outputs registered. Frame counter (7 bits min, sized to max(SERVE_FRAMES, MISS_FRAMES)) counts tick60 only. It clears on every state entry.
- Start event = rising edge of btn_start, detected against a registered copy. A button held through reset does not start a game.
- IDLE: ball_run=0. Start event clears score, loads lives=LIVES, level=0 and hit counter=0, pulses ball_load, and moves to SERVE.
- SERVE: ball_run=0. On the SERVE_FRAMES-th tick60, moves to PLAY.
- PLAY: ball_run=1.
  - hit increments score_bcd as BCD (09→10). Score saturates at 99.
  - miss moves to MISS and decrements lives.
  - If hit and miss occur in the same cycle, miss wins and hit is discarded.
- MISS: ball_run=0. On the MISS_FRAMES-th tick60:
  - lives==0 → OVER.
  - otherwise → SERVE, pulsing ball_load.
- OVER: game_over=1, ball_run=0. Score and level hold. A start event behaves as in IDLE.
- hit/miss outside PLAY are ignored. Start events outside IDLE/OVER are ignored.

## Timing
- Reset values:
  - state=IDLE, ball_run=0, ball_load=0.
  - score_bcd=8'h00, lives=LIVES, level=0.
  - game_over=0, frame and hit counters 0.
  - Reset mid-game returns all of these immediately, asynchronously.
- Start edge sampled in cycle N → state=SERVE and ball_load=1 in N+1, ball_load=0 in N+2.
- SERVE_FRAMES-th tick60 in cycle N → state=PLAY, ball_run=1 in N+1.
- hit in N → score_bcd updated in N+1. miss in N → state=MISS, ball_run=0, lives-1 in N+1.
- MISS expiry tick in N → SERVE with ball_load=1, or OVER with game_over=1, in N+1.
- tick60 coincident with a state change counts toward nothing. The counter restarts from 0 in the new state.

## Configuration
- PONG_SPEEDUP_EN defined:
  - Hit counter active in PLAY.
  - The HITS_PER_LEVEL-th hit increments level (saturating at MAX_LEVEL) and clears the counter in the same cycle the score updates.
  - Level persists across serves and resets to 0 at game start.
- Undefined: no hit counter; level is constant 0.

## Test plan
- Reset, then btn_start 0→1 → ball_load pulses exactly 1 cycle, state=1; after 60 tick60 pulses state=2, ball_run=1.
- In PLAY, 12 hit pulses → score_bcd=8'h12; with PONG_SPEEDUP_EN, level=3. Another 4 hits → level stays 3.
- Preload score 99 via 99 hits, one more hit → score_bcd stays 8'h99.
- hit and miss in the same cycle → lives 3→2, score unchanged, state=3; after 120 ticks state=1 with ball_load pulse.
- Three misses with defaults → after third MISS expiry state=4, game_over=1, lives=0. Start edge → score 00, lives 3, state=1.
- rst low mid-PLAY with btn_start held → all outputs at reset values. Release rst with btn_start still high → stays IDLE until the button is released and pressed again.

Source files
------------

// File: rtl/pong_game_ctrl_if.sv
// pong_game_ctrl_if: game-event inputs and game-state outputs between the Pong controller and its surroundings
interface pong_game_ctrl_if;
  logic       i_tick60;
  logic       i_btn_start;
  logic       i_hit;
  logic       i_miss;
  logic       o_ball_run;
  logic       o_ball_load;
  logic [7:0] o_score_bcd;
  logic [1:0] o_lives;
  logic [1:0] o_level;
  logic [2:0] o_state;
  logic       o_game_over;
  modport master (
    output i_tick60, i_btn_start, i_hit, i_miss,
    input  o_ball_run, o_ball_load, o_score_bcd, o_lives, o_level, o_state, o_game_over
  );
  modport slave (
    input  i_tick60, i_btn_start, i_hit, i_miss,
    output o_ball_run, o_ball_load, o_score_bcd, o_lives, o_level, o_state, o_game_over
  );
endinterface

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: Pong game-flow FSM with BCD score, lives and speed level; macro PONG_SPEEDUP_EN enables hit-driven level increments
module pong_game_ctrl #(
  parameter int LIVES          = 3,
  parameter int SERVE_FRAMES   = 60,
  parameter int MISS_FRAMES    = 120,
  parameter int HITS_PER_LEVEL = 4,
  parameter int MAX_LEVEL      = 3
) (
  input logic             clk,
  input logic             rst,
  pong_game_ctrl_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_MISS  = 3'd3,
    S_OVER  = 3'd4
  } state_t;
  localparam int FMAX = (SERVE_FRAMES > MISS_FRAMES) ? SERVE_FRAMES : MISS_FRAMES;
  localparam int FW   = ($clog2(FMAX + 1) > 7) ? $clog2(FMAX + 1) : 7;
  state_t        r_state;
  state_t        w_next;
  logic [FW-1:0] r_frame;
  logic          r_btn;
  logic [7:0]    r_score;
  logic [1:0]    r_lives;
  logic          r_run;
  logic          r_load;
  logic          r_over;
  logic          w_load;
  logic          w_start;
  logic          w_play_hit;
  logic          w_play_miss;
  logic          w_timed;
  logic [7:0]    w_score_inc;
  assign w_start     = bus.i_btn_start & ~r_btn & ((r_state == S_IDLE) | (r_state == S_OVER));
  assign w_play_miss = (r_state == S_PLAY) & bus.i_miss;
  assign w_play_hit  = (r_state == S_PLAY) & bus.i_hit & ~bus.i_miss;
  assign w_timed     = (r_state == S_SERVE) | (r_state == S_MISS);
  assign w_score_inc = (r_score == 8'h99) ? r_score :
                       (r_score[3:0] == 4'd9) ? {r_score[7:4] + 4'd1, 4'd0} :
                       {r_score[7:4], r_score[3:0] + 4'd1};
  // Registered copy of the button; resets high so a button held through reset is not a start
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_btn <= 1'b1;
    else      r_btn <= bus.i_btn_start;
  // Game phase register
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  // Phase transitions and the re-centre request that accompanies each entry into SERVE
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    case (r_state)
      S_IDLE, S_OVER: if (w_start) begin
        w_next = S_SERVE;
        w_load = 1'b1;
      end
      S_SERVE: if (bus.i_tick60 && r_frame == FW'(SERVE_FRAMES - 1)) w_next = S_PLAY;
      S_PLAY:  if (bus.i_miss) w_next = S_MISS;
      S_MISS:  if (bus.i_tick60 && r_frame == FW'(MISS_FRAMES - 1)) begin
        w_next = (r_lives == 2'd0) ? S_OVER : S_SERVE;
        w_load = (r_lives != 2'd0);
      end
      default: w_next = S_IDLE;
    endcase
  end
  // Frame pacing, score, lives and registered phase outputs
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_frame <= '0;
      r_score <= 8'h00;
      r_lives <= 2'(LIVES);
      r_run   <= 1'b0;
      r_load  <= 1'b0;
      r_over  <= 1'b0;
    end else begin
      r_frame <= (w_next != r_state) ? '0 : (bus.i_tick60 && w_timed) ? r_frame + FW'(1) : r_frame;
      r_score <= w_start ? 8'h00 : w_play_hit ? w_score_inc : r_score;
      r_lives <= w_start ? 2'(LIVES) : w_play_miss ? r_lives - 2'd1 : r_lives;
      r_run   <= (w_next == S_PLAY);
      r_load  <= w_load;
      r_over  <= (w_next == S_OVER);
    end
`ifdef PONG_SPEEDUP_EN
  localparam int HW = (HITS_PER_LEVEL > 1) ? $clog2(HITS_PER_LEVEL) : 1;
  logic [HW-1:0] r_hits;
  logic [1:0]    r_level;
  // Every HITS_PER_LEVEL-th paddle hit raises the speed level, saturating at MAX_LEVEL
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_hits  <= '0;
      r_level <= 2'd0;
    end else if (w_start) begin
      r_hits  <= '0;
      r_level <= 2'd0;
    end else if (w_play_hit) begin
      r_hits  <= (r_hits == HW'(HITS_PER_LEVEL - 1)) ? '0 : r_hits + HW'(1);
      r_level <= (r_hits != HW'(HITS_PER_LEVEL - 1) || r_level >= 2'(MAX_LEVEL)) ? r_level : r_level + 2'd1;
    end
  assign bus.o_level = r_level;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^{HITS_PER_LEVEL, MAX_LEVEL};
  assign bus.o_level  = 2'd0;
`endif
  assign bus.o_state     = r_state;
  assign bus.o_ball_run  = r_run;
  assign bus.o_ball_load = r_load;
  assign bus.o_score_bcd = r_score;
  assign bus.o_lives     = r_lives;
  assign bus.o_game_over = r_over;
endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb_pong_game_ctrl: directed scenario bench for the Pong game-flow controller
module tb_pong_game_ctrl;
`ifdef PONG_SPEEDUP_EN
  localparam bit SPD = 1'b1;
`else
  localparam bit SPD = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  pong_game_ctrl_if bus();
  pong_game_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      bus.i_tick60 = 1'b1;
      @(negedge clk);
      bus.i_tick60 = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic hits(input int n);
    bus.i_hit = 1'b1;
    cyc(n);
    bus.i_hit = 1'b0;
  endtask

  task automatic test_reset;
    cyc(2);
    checks++; if (bus.o_state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", bus.o_state); end
    checks++; if (bus.o_ball_run !== 1'b0 || bus.o_ball_load !== 1'b0 || bus.o_game_over !== 1'b0) begin errors++; $display("FAIL reset_flags got run=%b load=%b over=%b exp 0 0 0", bus.o_ball_run, bus.o_ball_load, bus.o_game_over); end
    checks++; if (bus.o_score_bcd !== 8'h00 || bus.o_lives !== 2'd3 || bus.o_level !== 2'd0) begin errors++; $display("FAIL reset_vals got score=%h lives=%0d level=%0d exp 00 3 0", bus.o_score_bcd, bus.o_lives, bus.o_level); end
    rst = 1'b1;
    cyc(2);
    checks++; if (bus.o_state !== 3'd0) begin errors++; $display("FAIL idle_hold got %0d exp 0", bus.o_state); end
  endtask

  task automatic test_start_serve;
    bus.i_btn_start = 1'b1;
    cyc(1);
    checks++; if (bus.o_state !== 3'd1 || bus.o_ball_load !== 1'b1) begin errors++; $display("FAIL start_serve got state=%0d load=%b exp 1 1", bus.o_state, bus.o_ball_load); end
    cyc(1);
    checks++; if (bus.o_ball_load !== 1'b0) begin errors++; $display("FAIL start_load_width got %b exp 0", bus.o_ball_load); end
    bus.i_btn_start = 1'b0;
    ticks(59);
    checks++; if (bus.o_state !== 3'd1 || bus.o_ball_run !== 1'b0) begin errors++; $display("FAIL serve_59 got state=%0d run=%b exp 1 0", bus.o_state, bus.o_ball_run); end
    ticks(1);
    checks++; if (bus.o_state !== 3'd2 || bus.o_ball_run !== 1'b1) begin errors++; $display("FAIL serve_60 got state=%0d run=%b exp 2 1", bus.o_state, bus.o_ball_run); end
  endtask

  task automatic test_score;
    hits(9);
    checks++; if (bus.o_score_bcd !== 8'h09) begin errors++; $display("FAIL score_9 got %h exp 09", bus.o_score_bcd); end
    hits(1);
    checks++; if (bus.o_score_bcd !== 8'h10 || bus.o_level !== (SPD ? 2'd2 : 2'd0)) begin errors++; $display("FAIL score_10 got score=%h level=%0d exp 10 %0d", bus.o_score_bcd, bus.o_level, SPD ? 2 : 0); end
    hits(2);
    checks++; if (bus.o_score_bcd !== 8'h12 || bus.o_level !== (SPD ? 2'd3 : 2'd0)) begin errors++; $display("FAIL score_12 got score=%h level=%0d exp 12 %0d", bus.o_score_bcd, bus.o_level, SPD ? 3 : 0); end
    hits(4);
    checks++; if (bus.o_score_bcd !== 8'h16 || bus.o_level !== (SPD ? 2'd3 : 2'd0)) begin errors++; $display("FAIL level_sat got score=%h level=%0d exp 16 %0d", bus.o_score_bcd, bus.o_level, SPD ? 3 : 0); end
  endtask

  task automatic test_saturate;
    hits(83);
    checks++; if (bus.o_score_bcd !== 8'h99) begin errors++; $display("FAIL score_99 got %h exp 99", bus.o_score_bcd); end
    hits(1);
    checks++; if (bus.o_score_bcd !== 8'h99 || bus.o_state !== 3'd2) begin errors++; $display("FAIL score_sat got score=%h state=%0d exp 99 2", bus.o_score_bcd, bus.o_state); end
  endtask

  task automatic test_hit_miss;
    bus.i_hit = 1'b1;
    bus.i_miss = 1'b1;
    cyc(1);
    bus.i_hit = 1'b0;
    bus.i_miss = 1'b0;
    checks++; if (bus.o_lives !== 2'd2 || bus.o_score_bcd !== 8'h99 || bus.o_state !== 3'd3 || bus.o_ball_run !== 1'b0) begin errors++; $display("FAIL hit_miss got lives=%0d score=%h state=%0d run=%b exp 2 99 3 0", bus.o_lives, bus.o_score_bcd, bus.o_state, bus.o_ball_run); end
    bus.i_miss = 1'b1;
    cyc(1);
    bus.i_miss = 1'b0;
    checks++; if (bus.o_lives !== 2'd2) begin errors++; $display("FAIL miss_in_miss got lives=%0d exp 2", bus.o_lives); end
    ticks(119);
    checks++; if (bus.o_state !== 3'd3) begin errors++; $display("FAIL miss_119 got %0d exp 3", bus.o_state); end
    ticks(1);
    checks++; if (bus.o_state !== 3'd1 || bus.o_ball_load !== 1'b0) begin errors++; $display("FAIL miss_120 got state=%0d load=%b exp 1 0", bus.o_state, bus.o_ball_load); end
  endtask

  task automatic test_reserve_load;
    ticks(59);
    bus.i_tick60 = 1'b1;
    cyc(1);
    bus.i_tick60 = 1'b0;
    checks++; if (bus.o_state !== 3'd2) begin errors++; $display("FAIL reserve_play got %0d exp 2", bus.o_state); end
    bus.i_miss = 1'b1;
    cyc(1);
    bus.i_miss = 1'b0;
    checks++; if (bus.o_lives !== 2'd1 || bus.o_state !== 3'd3) begin errors++; $display("FAIL miss2 got lives=%0d state=%0d exp 1 3", bus.o_lives, bus.o_state); end
    ticks(119);
    bus.i_tick60 = 1'b1;
    cyc(1);
    bus.i_tick60 = 1'b0;
    checks++; if (bus.o_state !== 3'd1 || bus.o_ball_load !== 1'b1) begin errors++; $display("FAIL reserve_load got state=%0d load=%b exp 1 1", bus.o_state, bus.o_ball_load); end
    cyc(1);
    checks++; if (bus.o_ball_load !== 1'b0) begin errors++; $display("FAIL reserve_load_width got %b exp 0", bus.o_ball_load); end
    bus.i_btn_start = 1'b1;
    cyc(1);
    bus.i_btn_start = 1'b0;
    cyc(1);
    checks++; if (bus.o_state !== 3'd1 || bus.o_lives !== 2'd1 || bus.o_ball_load !== 1'b0) begin errors++; $display("FAIL start_in_serve got state=%0d lives=%0d load=%b exp 1 1 0", bus.o_state, bus.o_lives, bus.o_ball_load); end
  endtask

  task automatic test_game_over;
    ticks(60);
    bus.i_miss = 1'b1;
    cyc(1);
    bus.i_miss = 1'b0;
    checks++; if (bus.o_lives !== 2'd0 || bus.o_state !== 3'd3) begin errors++; $display("FAIL miss3 got lives=%0d state=%0d exp 0 3", bus.o_lives, bus.o_state); end
    ticks(120);
    checks++; if (bus.o_state !== 3'd4 || bus.o_game_over !== 1'b1 || bus.o_lives !== 2'd0 || bus.o_ball_run !== 1'b0 || bus.o_ball_load !== 1'b0) begin errors++; $display("FAIL over got state=%0d over=%b lives=%0d run=%b load=%b exp 4 1 0 0 0", bus.o_state, bus.o_game_over, bus.o_lives, bus.o_ball_run, bus.o_ball_load); end
    checks++; if (bus.o_score_bcd !== 8'h99 || bus.o_level !== (SPD ? 2'd3 : 2'd0)) begin errors++; $display("FAIL over_hold got score=%h level=%0d exp 99 %0d", bus.o_score_bcd, bus.o_level, SPD ? 3 : 0); end
    bus.i_btn_start = 1'b1;
    cyc(1);
    bus.i_btn_start = 1'b0;
    checks++; if (bus.o_state !== 3'd1 || bus.o_score_bcd !== 8'h00 || bus.o_lives !== 2'd3 || bus.o_level !== 2'd0 || bus.o_game_over !== 1'b0 || bus.o_ball_load !== 1'b1) begin errors++; $display("FAIL restart got state=%0d score=%h lives=%0d level=%0d over=%b load=%b exp 1 00 3 0 0 1", bus.o_state, bus.o_score_bcd, bus.o_lives, bus.o_level, bus.o_game_over, bus.o_ball_load); end
  endtask

  task automatic test_reset_midgame;
    ticks(60);
    hits(3);
    checks++; if (bus.o_score_bcd !== 8'h03 || bus.o_state !== 3'd2) begin errors++; $display("FAIL mid_play got score=%h state=%0d exp 03 2", bus.o_score_bcd, bus.o_state); end
    bus.i_btn_start = 1'b1;
    cyc(1);
    checks++; if (bus.o_state !== 3'd2 || bus.o_score_bcd !== 8'h03) begin errors++; $display("FAIL start_in_play got state=%0d score=%h exp 2 03", bus.o_state, bus.o_score_bcd); end
    #2 rst = 1'b0;
    #1;
    checks++; if (bus.o_state !== 3'd0 || bus.o_ball_run !== 1'b0 || bus.o_ball_load !== 1'b0 || bus.o_game_over !== 1'b0) begin errors++; $display("FAIL async_rst_ctl got state=%0d run=%b load=%b over=%b exp 0 0 0 0", bus.o_state, bus.o_ball_run, bus.o_ball_load, bus.o_game_over); end
    checks++; if (bus.o_score_bcd !== 8'h00 || bus.o_lives !== 2'd3 || bus.o_level !== 2'd0) begin errors++; $display("FAIL async_rst_vals got score=%h lives=%0d level=%0d exp 00 3 0", bus.o_score_bcd, bus.o_lives, bus.o_level); end
    cyc(2);
    rst = 1'b1;
    cyc(3);
    checks++; if (bus.o_state !== 3'd0 || bus.o_ball_load !== 1'b0) begin errors++; $display("FAIL held_btn got state=%0d load=%b exp 0 0", bus.o_state, bus.o_ball_load); end
    bus.i_btn_start = 1'b0;
    cyc(1);
    bus.i_btn_start = 1'b1;
    cyc(1);
    bus.i_btn_start = 1'b0;
    checks++; if (bus.o_state !== 3'd1 || bus.o_ball_load !== 1'b1) begin errors++; $display("FAIL repress got state=%0d load=%b exp 1 1", bus.o_state, bus.o_ball_load); end
    hits(1);
    checks++; if (bus.o_score_bcd !== 8'h00) begin errors++; $display("FAIL hit_in_serve got %h exp 00", bus.o_score_bcd); end
  endtask

  initial begin
    bus.i_tick60 = 1'b0;
    bus.i_btn_start = 1'b0;
    bus.i_hit = 1'b0;
    bus.i_miss = 1'b0;
    test_reset();
    test_start_serve();
    test_score();
    test_saturate();
    test_hit_miss();
    test_reserve_load();
    test_game_over();
    test_reset_midgame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
